// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pkg
// Description : Shared types and helpers for the ADC frame alignment slice:
//               alignment state encoding, default frame word, sample width.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package adc_pkg;

  // State encodings kept as explicit constants for legacy tooling; the enum
  // below reuses them so both views always agree.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_SLIP    = 3'd2;
  localparam logic [2:0] ST_SETTLE  = 3'd3;
  localparam logic [2:0] ST_LOCKING = 3'd4;
  localparam logic [2:0] ST_LOCKED  = 3'd5;
  localparam logic [2:0] ST_FAIL    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_CHECK   = ST_CHECK,
    S_SLIP    = ST_SLIP,
    S_SETTLE  = ST_SETTLE,
    S_LOCKING = ST_LOCKING,
    S_LOCKED  = ST_LOCKED,
    S_FAIL    = ST_FAIL
  } align_state_t;

  // Frame word seen on the frame lane once the deserialisers are aligned.
  localparam logic [7:0] DEFAULT_FRAME_PATTERN = 8'hF0;

  // One assembled sample carries both lanes of a channel.
  function automatic int sample_w(input int ser_w);
    return 2 * ser_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_lane_merge.sv
`default_nettype none
// ============================================================================
// Module      : adc_lane_merge
// Description : Interleaves the two serial lanes of one ADC channel into a
//               single sample word and registers it with its valid flag.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module adc_lane_merge
  import adc_pkg::*;
#(
  parameter int SER_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        valid_in,
  input  logic [SER_W-1:0]            lane0,
  input  logic [SER_W-1:0]            lane1,
  output logic [sample_w(SER_W)-1:0]  sample,
  output logic                        valid
);

  localparam int SW = sample_w(SER_W);

  logic [SW-1:0] merged;

  // Lane 1 carries the odd sample bits, lane 0 the even ones.
  always_comb begin
    merged = '0;
    for (int k = 0; k < SER_W; k++) begin
      merged[2*k]   = lane0[k];
      merged[2*k+1] = lane1[k];
    end
  end

  // Capture every enabled cycle; valid is forced low while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= en & valid_in;
      if (en) begin
        sample <= merged;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_frame_align.sv
`default_nettype none
// ============================================================================
// Module      : adc_frame_align
// Description : Frame-clock bitslip search, lock confirmation and loss-of-lock
//               monitoring for NUM_CH two-lane ADC channels, plus sample
//               assembly with per-frame validity.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module adc_frame_align
  import adc_pkg::*;
#(
  parameter int               NUM_CH        = 4,
  parameter int               SER_W         = 8,
  parameter logic [SER_W-1:0] FRAME_PATTERN = SER_W'(DEFAULT_FRAME_PATTERN),
  parameter int               SETTLE_CYC    = 3,
  parameter int               LOCK_CNT      = 16,
  parameter int               MISS_LIMIT    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic [SER_W-1:0]                      frm_data,
  input  logic [NUM_CH*SER_W-1:0]               lane0_data,
  input  logic [NUM_CH*SER_W-1:0]               lane1_data,
  output logic                                  bitslip,
  output logic                                  aligned,
  output logic                                  align_err,
  output logic [$clog2(SER_W):0]                slip_count,
  output logic [7:0]                            relock_count,
  output logic [NUM_CH*sample_w(SER_W)-1:0]     sample_o,
  output logic [NUM_CH-1:0]                     sample_valid
);

  localparam int SW      = sample_w(SER_W);
  localparam int SLIP_W  = $clog2(SER_W) + 1;
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(MISS_LIMIT + 1);
  localparam int TMR_W   = $clog2(SETTLE_CYC + 1);

  localparam logic [SLIP_W-1:0]  SLIP_MAX_C = SLIP_W'(SER_W);
  localparam logic [MATCH_W-1:0] LOCK_C     = MATCH_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0]  MISS_C     = MISS_W'(MISS_LIMIT);
  localparam logic [TMR_W-1:0]   SETTLE_C   = TMR_W'(SETTLE_CYC);

  align_state_t        state;
  logic [MATCH_W-1:0]  match_cnt;
  logic [MISS_W-1:0]   miss_cnt;
  logic [TMR_W-1:0]    settle_tmr;

  logic                frm_match;
  logic                locked_good;
  logic [SLIP_W-1:0]   slip_inc;
  logic [MATCH_W-1:0]  match_nxt;
  logic [MISS_W-1:0]   miss_nxt;

  assign frm_match   = (frm_data == FRAME_PATTERN);
  assign locked_good = (state == S_LOCKED) && frm_match;
  // A slip taken from LOCKING after a full search must not wrap the count.
  assign slip_inc    = (slip_count == '1) ? slip_count : slip_count + 1'b1;
  assign match_nxt   = match_cnt + 1'b1;
  assign miss_nxt    = miss_cnt + 1'b1;

  // Alignment state machine; en low overrides every threshold decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bitslip      <= 1'b0;
      aligned      <= 1'b0;
      align_err    <= 1'b0;
      slip_count   <= '0;
      relock_count <= '0;
      match_cnt    <= '0;
      miss_cnt     <= '0;
      settle_tmr   <= '0;
    end else if (!en) begin
      state      <= S_IDLE;
      bitslip    <= 1'b0;
      aligned    <= 1'b0;
      align_err  <= 1'b0;
      slip_count <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      settle_tmr <= '0;
    end else begin
      // bitslip is only ever raised on entry to SLIP, so it lasts one cycle.
      bitslip <= 1'b0;
      case (state)
        S_IDLE: begin
          align_err <= 1'b0;
          state     <= S_CHECK;
        end

        S_CHECK: begin
          if (frm_match) begin
            miss_cnt <= '0;
            if (LOCK_CNT <= 1) begin
              match_cnt <= '0;
              aligned   <= 1'b1;
              state     <= S_LOCKED;
            end else begin
              match_cnt <= MATCH_W'(1);
              state     <= S_LOCKING;
            end
          end else if (slip_count >= SLIP_MAX_C) begin
            align_err <= 1'b1;
            state     <= S_FAIL;
          end else begin
            bitslip    <= 1'b1;
            slip_count <= slip_inc;
            state      <= S_SLIP;
          end
        end

        S_SLIP: begin
          settle_tmr <= SETTLE_C;
          state      <= S_SETTLE;
        end

        // Deserialiser output is unreliable right after a slip.
        S_SETTLE: begin
          if (settle_tmr <= TMR_W'(1)) begin
            settle_tmr <= '0;
            state      <= S_CHECK;
          end else begin
            settle_tmr <= settle_tmr - 1'b1;
          end
        end

        S_LOCKING: begin
          if (!frm_match) begin
            match_cnt  <= '0;
            bitslip    <= 1'b1;
            slip_count <= slip_inc;
            state      <= S_SLIP;
          end else if (match_nxt >= LOCK_C) begin
            match_cnt <= '0;
            miss_cnt  <= '0;
            aligned   <= 1'b1;
            state     <= S_LOCKED;
          end else begin
            match_cnt <= match_nxt;
          end
        end

        S_LOCKED: begin
          if (frm_match) begin
            miss_cnt <= '0;
          end else if (miss_nxt >= MISS_C) begin
            miss_cnt     <= '0;
            aligned      <= 1'b0;
            slip_count   <= '0;
            relock_count <= (relock_count == 8'hFF) ? relock_count
                                                    : relock_count + 8'd1;
            state        <= S_CHECK;
          end else begin
            miss_cnt <= miss_nxt;
          end
        end

        // Search exhausted: hold the error until en drops.
        S_FAIL: begin
          align_err <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // One merge/register slice per channel, sharing the frame-based valid.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    adc_lane_merge #(
      .SER_W (SER_W)
    ) u_merge (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .valid_in (locked_good),
      .lane0    (lane0_data[c*SER_W +: SER_W]),
      .lane1    (lane1_data[c*SER_W +: SER_W]),
      .sample   (sample_o[c*SW +: SW]),
      .valid    (sample_valid[c])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_frame_align
// Description : Directed self-checking bench for adc_frame_align; the frame
//               lane is modelled as the pattern rotated by a number of
//               outstanding slips, reduced by one on each bitslip pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_frame_align;

  localparam int         NUM_CH     = 4;
  localparam int         SER_W      = 8;
  localparam logic [7:0] PAT        = 8'hF0;
  localparam int         SETTLE_CYC = 3;
  localparam int         LOCK_CNT   = 16;
  localparam int         MISS_LIMIT = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   en;
  logic [SER_W-1:0]       frm_data;
  logic [NUM_CH*SER_W-1:0] lane0_data;
  logic [NUM_CH*SER_W-1:0] lane1_data;
  logic                   bitslip;
  logic                   aligned;
  logic                   align_err;
  logic [3:0]             slip_count;
  logic [7:0]             relock_count;
  logic [NUM_CH*16-1:0]   sample_o;
  logic [NUM_CH-1:0]      sample_valid;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  int   n_bs   = 0;
  int   rot    = 0;
  logic force_bad = 1'b0;
  logic [7:0] bad_val = 8'h00;
  logic prev_bs = 1'b0;

  adc_frame_align #(
    .NUM_CH        (NUM_CH),
    .SER_W         (SER_W),
    .FRAME_PATTERN (PAT),
    .SETTLE_CYC    (SETTLE_CYC),
    .LOCK_CNT      (LOCK_CNT),
    .MISS_LIMIT    (MISS_LIMIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .frm_data     (frm_data),
    .lane0_data   (lane0_data),
    .lane1_data   (lane1_data),
    .bitslip      (bitslip),
    .aligned      (aligned),
    .align_err    (align_err),
    .slip_count   (slip_count),
    .relock_count (relock_count),
    .sample_o     (sample_o),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] rol8(input logic [7:0] v, input int r);
    logic [15:0] t;
    t = {v, v} << r;
    return t[15:8];
  endfunction

  task automatic set_frm();
    frm_data = force_bad ? bad_val : rol8(PAT, rot);
  endtask

  // Advance one clock; observe #1 after the edge and let the frame model react.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bitslip) begin
      chk("bitslip_single_cycle", {63'b0, prev_bs}, 64'd0);
      n_bs++;
      if (rot > 0) rot--;
    end
    prev_bs = bitslip;
    set_frm();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int last;
    int np;

    rst_n      = 1'b0;
    en         = 1'b0;
    lane0_data = '0;
    lane1_data = '0;
    set_frm();
    tick();
    tick();

    // Reset state
    chk("rst_bitslip",      bitslip,      0);
    chk("rst_aligned",      aligned,      0);
    chk("rst_align_err",    align_err,    0);
    chk("rst_slip_count",   slip_count,   0);
    chk("rst_relock_count", relock_count, 0);
    chk("rst_sample_o",     sample_o,     0);
    chk("rst_sample_valid", sample_valid, 0);

    rst_n = 1'b1;
    tick();

    // Already aligned: no slips, lock after 1 CHECK + 16 matches
    rot = 0; force_bad = 1'b0; set_frm();
    n_bs = 0;
    en = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!aligned && n < 40);
    chk("aligned_lock_latency", n, 17);
    chk("aligned_no_bitslip",   n_bs, 0);
    chk("aligned_slip_count",   slip_count, 0);
    tick();
    chk("aligned_sample_valid", sample_valid, 4'hF);

    // Lane interleave: ch2 lane0=00 lane1=FF -> AAAA; ch0 56/DE -> B3BC
    lane0_data = 32'h12_00_34_56;
    lane1_data = 32'h9A_FF_BC_DE;
    tick();
    chk("sample_ch2",       sample_o[32 +: 16], 16'hAAAA);
    chk("sample_ch0",       sample_o[0  +: 16], 16'hB3BC);
    chk("sample_valid_ch",  sample_valid, 4'hF);

    // Three bad frames keep lock but invalidate those samples
    force_bad = 1'b1; bad_val = 8'h00; set_frm();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("miss3_aligned", aligned, 1);
      chk("miss3_valid",   sample_valid, 4'h0);
    end
    force_bad = 1'b0; set_frm();
    tick();
    chk("miss3_recover_aligned", aligned, 1);
    chk("miss3_recover_valid",   sample_valid, 4'hF);

    // Four consecutive bad frames drop lock and restart the search
    force_bad = 1'b1; set_frm();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("miss4_still_aligned", aligned, 1);
    end
    tick();
    chk("miss4_aligned",      aligned, 0);
    chk("miss4_relock_count", relock_count, 1);
    chk("miss4_slip_count",   slip_count, 0);
    tick();
    chk("miss4_research_bitslip", bitslip, 1);
    chk("miss4_research_slip",    slip_count, 1);

    en = 1'b0;
    tick();
    chk("en_low_aligned",    aligned, 0);
    chk("en_low_slip_count", slip_count, 0);
    chk("en_low_bitslip",    bitslip, 0);
    chk("en_low_relock",     relock_count, 1);

    // Frame rotated by 3: three pulses, four idle cycles between pulses
    force_bad = 1'b0; rot = 3; set_frm();
    n_bs = 0; np = 0; last = 0;
    en = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (bitslip) begin
        if (np > 0) chk("rot3_pulse_spacing", cyc - last, SETTLE_CYC + 2);
        last = cyc;
        np++;
      end
    end while (!aligned && n < 200);
    chk("rot3_locked",     aligned, 1);
    chk("rot3_pulses",     n_bs, 3);
    chk("rot3_slip_count", slip_count, 3);

    en = 1'b0;
    tick();

    // Never matching: 8 slips then FAIL, no further pulses
    force_bad = 1'b1; bad_val = 8'h55; set_frm();
    n_bs = 0;
    en = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!align_err && n < 200);
    chk("fail_align_err",  align_err, 1);
    chk("fail_pulses",     n_bs, 8);
    chk("fail_slip_count", slip_count, 8);
    for (int i = 0; i < 10; i++) tick();
    chk("fail_no_more_pulses", n_bs, 8);
    chk("fail_err_held",       align_err, 1);
    chk("fail_aligned",        aligned, 0);
    en = 1'b0;
    tick();
    chk("fail_clear_err",  align_err, 0);
    chk("fail_clear_slip", slip_count, 0);

    // Asynchronous reset in SETTLE, then a fresh search from slip_count 0
    force_bad = 1'b0; rot = 3; set_frm();
    en = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bitslip && n < 20);
    chk("arst_first_pulse", bitslip, 1);
    tick();
    chk("arst_pre_slip", slip_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_slip_count",   slip_count,   0);
    chk("arst_relock_count", relock_count, 0);
    chk("arst_sample_o",     sample_o,     0);
    chk("arst_bitslip",      bitslip,      0);
    chk("arst_aligned",      aligned,      0);
    chk("arst_align_err",    align_err,    0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_restart_slip0", slip_count, 0);
    tick();
    chk("arst_restart_pulse", bitslip, 1);
    chk("arst_restart_slip1", slip_count, 1);

    en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
